// File: rtl/write_buffer_pkg.sv
// write_buffer_pkg
// Shared definitions for the data-cache write-back buffer: default sizes and
// the drain state machine encoding.
//   WB_DEPTH    default number of buffer entries (power of two, >= 2)
//   WB_BLOCK_W  default cache block width in bits
//   MEM_DEPTH   address width of the backing dataram word space
//   WB_ADDR_W   block address width, matching the dataram addr port
//   wb_state_t  WB_IDLE / WB_WRITE drain states
package write_buffer_pkg;

    localparam int WB_DEPTH   = 4;
    localparam int WB_BLOCK_W = 128;
    localparam int MEM_DEPTH  = 12;
    localparam int WB_ADDR_W  = MEM_DEPTH - 2;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_t;

endpackage

// File: rtl/write_buffer_addr_match.sv
// wb_addr_match
// Comparator array: flags every valid buffer entry whose address equals the
// compare address. Priority/age selection is left to the instantiating module.
//   valid       per-entry valid bits
//   entry_addr  per-entry block addresses
//   cmp_addr    address to look up
//   match       per-entry match vector (valid && address equal)
module wb_addr_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0]            cmp_addr,
    output logic [DEPTH-1:0]             match
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match[gi] = valid[gi] && (entry_addr[gi] == cmp_addr);
    end

endmodule

// File: rtl/write_buffer.sv
// write_buffer
// Write-back buffer between the data cache and dataram. Accepts evicted dirty
// blocks in one cycle, coalesces repeat evictions of the same block, forwards
// buffered data to refill lookups, and drains entries to DRAM in FIFO order.
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   wb_valid/ready/addr/data   eviction push interface
//   rd_addr -> rd_hit, rd_data refill lookup (combinational, newest match)
//   refill_pending, flush      drain deferral / forced drain
//   dram_we/addr/in, dram_complete  DRAM write port (we held until complete)
//   count, empty               occupancy
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH   = WB_DEPTH,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int BLOCK_W = WB_BLOCK_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [BLOCK_W-1:0]         wb_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_hit,
    output logic [BLOCK_W-1:0]         rd_data,
    input  logic                       refill_pending,
    input  logic                       flush,
    output logic                       dram_we,
    output logic [ADDR_W-1:0]          dram_addr,
    output logic [BLOCK_W-1:0]         dram_in,
    input  logic                       dram_complete,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]             valid_reg;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_reg;
    logic [BLOCK_W-1:0]           data_reg [DEPTH];
    logic [PTR_W-1:0]             head_reg;
    logic [PTR_W-1:0]             tail_reg;
    logic [CNT_W-1:0]             count_reg;
    wb_state_t                    state_reg;
    wb_state_t                    state_next;

    logic [DEPTH-1:0] wb_match;
    logic [DEPTH-1:0] rd_match;
    logic             push;
    logic             pop;
    logic             alloc;
    logic             coal_hit;
    logic [PTR_W-1:0] coal_idx;
    logic [PTR_W-1:0] fwd_idx;

    wb_addr_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wb_match (
        .valid      (valid_reg),
        .entry_addr (addr_reg),
        .cmp_addr   (wb_addr),
        .match      (wb_match)
    );

    wb_addr_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_match (
        .valid      (valid_reg),
        .entry_addr (addr_reg),
        .cmp_addr   (rd_addr),
        .match      (rd_match)
    );

    assign wb_ready = (count_reg < CNT_W'(DEPTH));
    assign push     = wb_valid && wb_ready;
    assign pop      = (state_reg == WB_WRITE) && dram_complete;
    assign alloc    = push && !coal_hit;

    // Coalesce target: any matching entry except the head while it is being
    // written (its data must stay frozen). Because every push coalesces when
    // it can, at most one such entry exists for a given address.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_match[i] && !((state_reg == WB_WRITE) && (PTR_W'(i) == head_reg))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Forwarding: walk entries oldest (head) to newest so the last match
    // found is the newest copy of the block.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if (rd_match[fwd_idx]) begin
                rd_hit  = 1'b1;
                rd_data = data_reg[fwd_idx];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_IDLE: begin
                if ((count_reg != '0) &&
                    (!refill_pending || flush || (count_reg == CNT_W'(DEPTH)))) begin
                    state_next = WB_WRITE;
                end
            end
            WB_WRITE: begin
                if (dram_complete) begin
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= WB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            // Head and tail never coincide when both fire: a pop needs
            // count >= 1 and a push needs count < DEPTH.
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            if (alloc) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (alloc && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !alloc) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Entry payload storage; validity is tracked separately so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            if (coal_hit) begin
                data_reg[coal_idx] <= wb_data;
            end else begin
                data_reg[tail_reg] <= wb_data;
                addr_reg[tail_reg] <= wb_addr;
            end
        end
    end

    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign dram_we   = (state_reg == WB_WRITE);
    assign dram_addr = dram_we ? addr_reg[head_reg] : '0;
    assign dram_in   = dram_we ? data_reg[head_reg] : '0;

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;
    import write_buffer_pkg::*;

    localparam int DEPTH = WB_DEPTH;
    localparam int AW    = WB_ADDR_W;
    localparam int BW    = WB_BLOCK_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [AW-1:0] addr_t;
    typedef logic [BW-1:0] data_t;
    typedef struct {
        addr_t addr;
        data_t data;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          wb_valid;
    logic          wb_ready;
    addr_t         wb_addr;
    data_t         wb_data;
    addr_t         rd_addr;
    logic          rd_hit;
    data_t         rd_data;
    logic          refill_pending;
    logic          flush;
    logic          dram_we;
    addr_t         dram_addr;
    data_t         dram_in;
    logic          dram_complete;
    logic [CW-1:0] count;
    logic          empty;

    // Reference model: the buffer as an ordered list of blocks (oldest first)
    // plus a flag telling whether the oldest one is being written to DRAM.
    ent_t m_q[$];
    logic m_busy;
    int   n_tests;
    int   n_fail;

    write_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .rd_addr        (rd_addr),
        .rd_hit         (rd_hit),
        .rd_data        (rd_data),
        .refill_pending (refill_pending),
        .flush          (flush),
        .dram_we        (dram_we),
        .dram_addr      (dram_addr),
        .dram_in        (dram_in),
        .dram_complete  (dram_complete),
        .count          (count),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic data_t rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic e_hit(input addr_t a);
        foreach (m_q[i]) if (m_q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic data_t e_data(input addr_t a);
        for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i].addr == a) return m_q[i].data;
        return '0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int   pre_size;
        logic pre_busy;
        int   j;
        ent_t e;
        if (!rst) begin
            m_q.delete();
            m_busy = 1'b0;
            return;
        end
        pre_size = m_q.size();
        pre_busy = m_busy;
        if (pre_busy) m_busy = !dram_complete;
        else          m_busy = (pre_size > 0) && (!refill_pending || flush || pre_size == DEPTH);
        if (wb_valid && pre_size < DEPTH) begin
            j = -1;
            for (int i = 0; i < pre_size; i++)
                if (m_q[i].addr == wb_addr && !(pre_busy && i == 0)) j = i;
            if (j >= 0) begin
                e = m_q[j];
                e.data = wb_data;
                m_q[j] = e;
                $display("[TB] t=%0t coalesce addr=%h data=%h", $time, wb_addr, wb_data);
            end else begin
                e.addr = wb_addr;
                e.data = wb_data;
                m_q.push_back(e);
                $display("[TB] t=%0t push     addr=%h data=%h", $time, wb_addr, wb_data);
            end
        end
        if (pre_busy && dram_complete) begin
            $display("[TB] t=%0t drained  addr=%h data=%h", $time, m_q[0].addr, m_q[0].data);
            void'(m_q.pop_front());
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input addr_t a, input data_t d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        wb_valid = 1'b1;
        wb_addr  = addr_t'(5);
        hard_reset();
        wb_valid = 1'b0;
        rd_addr  = addr_t'(5);
        #1;
        n_tests++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", wb_ready); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %b want 0", rd_hit); end
        n_tests++; if (rd_data !== data_t'(0)) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_tests++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL reset_dram_we: got %b want 0", dram_we); end
        n_tests++; if (dram_addr !== addr_t'(0)) begin n_fail++; $display("FAIL reset_dram_addr: got %h want 0", dram_addr); end
        n_tests++; if (dram_in !== data_t'(0)) begin n_fail++; $display("FAIL reset_dram_in: got %h want 0", dram_in); end
    endtask

    task automatic test_basic_drain();
        data_t d1;
        d1 = rand_block();
        hard_reset();
        refill_pending = 1'b0;
        push(addr_t'('h10), d1);
        rd_addr = addr_t'('h10);
        #1;
        n_tests++; if (count !== CW'(1) || dram_we !== 1'b0) begin n_fail++; $display("FAIL basic_after_push: count=%0d we=%b, want count=1 we=0", count, dram_we); end
        n_tests++; if (rd_hit !== 1'b1 || rd_data !== d1) begin n_fail++; $display("FAIL basic_fwd: hit=%b data=%h, want hit=1 data=%h", rd_hit, rd_data, d1); end
        tick();
        n_tests++; if (dram_we !== 1'b1 || dram_addr !== addr_t'('h10) || dram_in !== d1) begin n_fail++; $display("FAIL basic_write: we=%b addr=%h data=%h, want we=1 addr=10 data=%h", dram_we, dram_addr, dram_in, d1); end
        repeat (5) tick();
        n_tests++; if (dram_we !== 1'b1 || dram_in !== d1) begin n_fail++; $display("FAIL basic_hold: we=%b data=%h, want we=1 data=%h", dram_we, dram_in, d1); end
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        #1;
        n_tests++; if (empty !== 1'b1 || dram_we !== 1'b0 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL basic_done: empty=%b we=%b hit=%b, want 1 0 0", empty, dram_we, rd_hit); end
    endtask

    task automatic test_full();
        data_t d[4];
        int    t;
        hard_reset();
        refill_pending = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_block();
            push(addr_t'('h40 + i), d[i]);
        end
        n_tests++; if (wb_ready !== 1'b0 || count !== CW'(4)) begin n_fail++; $display("FAIL full_ready: ready=%b count=%0d, want 0 4", wb_ready, count); end
        n_tests++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL full_not_yet: we=%b want 0", dram_we); end
        tick();
        n_tests++; if (dram_we !== 1'b1 || dram_addr !== addr_t'('h40)) begin n_fail++; $display("FAIL full_start: we=%b addr=%h, want 1 40", dram_we, dram_addr); end
        refill_pending = 1'b0;
        for (int w = 0; w < 4; w++) begin
            t = 0;
            while (!dram_we && t < 20) begin tick(); t++; end
            n_tests++;
            if (dram_we !== 1'b1 || dram_addr !== addr_t'('h40 + w) || dram_in !== d[w]) begin
                n_fail++;
                $display("FAIL full_order[%0d]: we=%b addr=%h data=%h, want we=1 addr=%h data=%h", w, dram_we, dram_addr, dram_in, addr_t'('h40 + w), d[w]);
            end
            dram_complete = 1'b1;
            tick();
            dram_complete = 1'b0;
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty: got %b want 1", empty); end
    endtask

    task automatic test_coalesce();
        data_t d0, d1, d2;
        addr_t ea[2];
        data_t ed[2];
        int    t;
        d0 = rand_block(); d1 = rand_block(); d2 = rand_block();
        hard_reset();
        refill_pending = 1'b1;
        push(addr_t'('h50), d0);
        push(addr_t'('h20), d1);
        push(addr_t'('h20), d2);
        rd_addr = addr_t'('h20);
        #1;
        n_tests++; if (count !== CW'(2)) begin n_fail++; $display("FAIL coal_count: got %0d want 2", count); end
        n_tests++; if (rd_hit !== 1'b1 || rd_data !== d2) begin n_fail++; $display("FAIL coal_fwd: hit=%b data=%h, want 1 %h", rd_hit, rd_data, d2); end
        refill_pending = 1'b0;
        ea[0] = addr_t'('h50); ed[0] = d0;
        ea[1] = addr_t'('h20); ed[1] = d2;
        for (int w = 0; w < 2; w++) begin
            t = 0;
            while (!dram_we && t < 20) begin tick(); t++; end
            n_tests++;
            if (dram_we !== 1'b1 || dram_addr !== ea[w] || dram_in !== ed[w]) begin
                n_fail++;
                $display("FAIL coal_drain[%0d]: we=%b addr=%h data=%h, want we=1 addr=%h data=%h", w, dram_we, dram_addr, dram_in, ea[w], ed[w]);
            end
            dram_complete = 1'b1;
            tick();
            dram_complete = 1'b0;
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL coal_empty: got %b want 1", empty); end
    endtask

    task automatic test_inflight();
        data_t d1, d2;
        d1 = rand_block(); d2 = rand_block();
        hard_reset();
        refill_pending = 1'b0;
        push(addr_t'('h30), d1);
        tick();
        n_tests++; if (dram_we !== 1'b1 || dram_in !== d1) begin n_fail++; $display("FAIL infl_start: we=%b data=%h, want 1 %h", dram_we, dram_in, d1); end
        push(addr_t'('h30), d2);
        rd_addr = addr_t'('h30);
        #1;
        n_tests++; if (count !== CW'(2) || dram_in !== d1) begin n_fail++; $display("FAIL infl_frozen: count=%0d data=%h, want 2 %h", count, dram_in, d1); end
        n_tests++; if (rd_hit !== 1'b1 || rd_data !== d2) begin n_fail++; $display("FAIL infl_fwd: hit=%b data=%h, want 1 %h", rd_hit, rd_data, d2); end
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        n_tests++; if (dram_we !== 1'b0 || count !== CW'(1)) begin n_fail++; $display("FAIL infl_bubble: we=%b count=%0d, want 0 1", dram_we, count); end
        tick();
        n_tests++; if (dram_we !== 1'b1 || dram_addr !== addr_t'('h30) || dram_in !== d2) begin n_fail++; $display("FAIL infl_second: we=%b addr=%h data=%h, want 1 30 %h", dram_we, dram_addr, dram_in, d2); end
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL infl_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_pop();
        data_t d[4];
        data_t de;
        int    t;
        hard_reset();
        refill_pending = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_block();
            push(addr_t'('h60 + i), d[i]);
        end
        tick();
        de = rand_block();
        wb_valid = 1'b1; wb_addr = addr_t'('h70); wb_data = de;
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        rd_addr = addr_t'('h70);
        #1;
        n_tests++; if (count !== CW'(3) || rd_hit !== 1'b0) begin n_fail++; $display("FAIL fpop_reject: count=%0d hit=%b, want 3 0", count, rd_hit); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_tests++; if (count !== CW'(4) || rd_hit !== 1'b1 || rd_data !== de) begin n_fail++; $display("FAIL fpop_accept: count=%0d hit=%b data=%h, want 4 1 %h", count, rd_hit, rd_data, de); end
        flush = 1'b1;
        for (int w = 0; w < 4; w++) begin
            t = 0;
            while (!dram_we && t < 20) begin tick(); t++; end
            n_tests++;
            if (dram_we !== 1'b1 || dram_addr !== ((w < 3) ? addr_t'('h61 + w) : addr_t'('h70)) || dram_in !== ((w < 3) ? d[w+1] : de)) begin
                n_fail++;
                $display("FAIL fpop_wrap[%0d]: we=%b addr=%h data=%h", w, dram_we, dram_addr, dram_in);
            end
            dram_complete = 1'b1;
            tick();
            dram_complete = 1'b0;
        end
        flush = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpop_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        hard_reset();
        refill_pending = 1'b1;
        for (int i = 0; i < 3; i++) push(addr_t'('h08 + i), rand_block());
        flush = 1'b1;
        tick();
        n_tests++; if (dram_we !== 1'b1 || count !== CW'(3)) begin n_fail++; $display("FAIL rmid_write: we=%b count=%0d, want 1 3", dram_we, count); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        flush = 1'b0;
        n_tests++; if (count !== CW'(0) || dram_we !== 1'b0 || dram_in !== data_t'(0)) begin n_fail++; $display("FAIL rmid_state: count=%0d we=%b data=%h, want 0 0 0", count, dram_we, dram_in); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = addr_t'('h08 + i);
            #1;
            n_tests++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL rmid_hit[%0d]: got %b want 0", i, rd_hit); end
        end
    endtask

    task automatic test_random();
        hard_reset();
        for (int c = 0; c < 600; c++) begin
            wb_valid       = ($urandom_range(0, 1) == 1);
            wb_addr        = addr_t'($urandom_range(0, 5));
            wb_data        = rand_block();
            rd_addr        = addr_t'($urandom_range(0, 5));
            refill_pending = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 7) == 0);
            dram_complete  = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 99) != 0);
            #1;
            n_tests++;
            if (wb_ready !== (m_q.size() < DEPTH) || count !== CW'(m_q.size()) || empty !== (m_q.size() == 0)) begin
                n_fail++;
                $display("FAIL rand_occ[%0d]: ready=%b count=%0d empty=%b, want count=%0d", c, wb_ready, count, empty, m_q.size());
            end
            n_tests++;
            if (rd_hit !== e_hit(rd_addr) || rd_data !== e_data(rd_addr)) begin
                n_fail++;
                $display("FAIL rand_fwd[%0d]: addr=%h hit=%b data=%h, want hit=%b data=%h", c, rd_addr, rd_hit, rd_data, e_hit(rd_addr), e_data(rd_addr));
            end
            n_tests++;
            if (dram_we !== m_busy || dram_addr !== (m_busy ? m_q[0].addr : addr_t'(0)) || dram_in !== (m_busy ? m_q[0].data : data_t'(0))) begin
                n_fail++;
                $display("FAIL rand_dram[%0d]: we=%b addr=%h data=%h, want we=%b", c, dram_we, dram_addr, dram_in, m_busy);
            end
            tick();
        end
        rst = 1'b1;
        dram_complete = 1'b0;
        flush = 1'b0;
        wb_valid = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        m_busy         = 1'b0;
        rst            = 1'b0;
        wb_valid       = 1'b0;
        wb_addr        = '0;
        wb_data        = '0;
        rd_addr        = '0;
        refill_pending = 1'b0;
        flush          = 1'b0;
        dram_complete  = 1'b0;
        test_reset();
        test_basic_drain();
        test_full();
        test_coalesce();
        test_inflight();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
# write_buffer

Four-entry write-back buffer between the data cache and `dataram`. It accepts evicted dirty 128-bit blocks from the cache in a single cycle and drains them to DRAM in the background, so a refill can proceed without waiting for the eviction write. It coalesces repeat evictions of the same block address and forwards buffered data to cache refill lookups so that DRAM is never read stale.

## Interface
- `DEPTH`, 4: number of entries; must be a power of two, at least 2.
- `ADDR_W`, `MEM_DEPTH-2`: block/word address width, matching the `dataram` addr port.
- `BLOCK_W`, 128: block width in bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `wb_valid`  in  1  cache presents an evicted block.
- `wb_ready`  out  1  buffer can accept; equals `count < DEPTH`.
- `wb_addr`  in  ADDR_W  block address of the eviction.
- `wb_data`  in  BLOCK_W  block data.
- `rd_addr`  in  ADDR_W  refill lookup address (combinational).
- `rd_hit`  out  1  a buffered entry matches `rd_addr`.
- `rd_data`  out  BLOCK_W  newest matching entry's data; 0 when `rd_hit`=0.
- `refill_pending`  in  1  cache refill wants DRAM; this input defers draining.
- `flush`  in  1  forces draining regardless of `refill_pending`.
- `dram_we`  out  1  DRAM write strobe; held high until complete.
- `dram_addr`  out  ADDR_W  head entry address while `dram_we`=1; 0 otherwise.
- `dram_in`  out  BLOCK_W  head entry data while `dram_we`=1; 0 otherwise.
- `dram_complete`  in  1  DRAM write finished; sampled only in WRITE.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `empty`  out  1  `count == 0`.

## Operation
- Circular FIFO with head pointer, tail pointer and count. Each entry holds a valid bit, an address and data.
- **Push.** A push is accepted at an edge where `wb_valid && wb_ready`.
  - Coalesce: if a valid entry with the same address exists and it is not the head entry currently in WRITE, overwrite its data in place. Count is unchanged.
  - Otherwise write the block at the tail, advance the tail and increment count.
- **FSM.** States are IDLE and WRITE.
  - IDLE → WRITE when `count>0 && (!refill_pending || flush || count==DEPTH)`.
  - WRITE → IDLE on an edge with `dram_complete`=1. That edge pops the head: clear valid, advance head, decrement count.
  - `dram_we` = (state==WRITE). It is decoded from the registered state.
  - The head address and data are frozen for the whole of WRITE, because in-flight coalescing is forbidden.
- **Simultaneous push and pop.** Count is net unchanged and the tail and head both advance. `wb_ready` is evaluated on the pre-edge count, so a full buffer does not accept on the pop edge.
- **Forwarding.** Compare `rd_addr` against all valid entries and select the newest by age from head. The head entry in WRITE does participate.
  - With coalescing, at most two entries can match: the in-flight head and one newer entry. The newer one wins.
- **Wrap-around.** Pointers wrap modulo DEPTH and count disambiguates full from empty.
- **Reset.**
  - All entries are invalidated, pointers and count go to 0, and the FSM goes to IDLE.
  - An in-flight DRAM write is abandoned. `dataram` shares `rst`.
- Reset values of outputs:
  - `wb_ready`=1, `empty`=1, `count`=0
  - `rd_hit`=0, `rd_data`=0
  - `dram_we`=0, `dram_addr`=0, `dram_in`=0

## Timing
- A block pushed at edge N is visible to `rd_hit` in the cycle after edge N and counted in `count` after edge N.
- Earliest drain: state goes to WRITE at edge N+1 and `dram_we` is high from N+1.
- Pop at completion edge K. The next entry cannot enter WRITE before edge K+1, so there is a minimum one-cycle bubble with `dram_we` low between writes.
- `wb_ready`, `rd_hit` and `rd_data` are combinational from registered state and `rd_addr`. There is no input-to-`dram_*` combinational path.
- `refill_pending` rising while in WRITE does not abort the write.

## Structure
- The shared defines header, next to `mips_defines.v`, holds:
  - the `WB_IDLE`/`WB_WRITE` state encodings;
  - `WB_DEPTH` and `BLOCK_W` defaults.
- Sub-module `wb_addr_match` is a comparator array producing a per-entry match vector. Newest-match selection and priority ordering live in the top module.

## Test plan
- Push A=0x10 with data D1 on an empty buffer, `refill_pending`=0 → `dram_we` high one cycle later with `dram_addr`=0x10 and `dram_in`=D1. Complete after 5 cycles → `empty`=1 and `dram_we`=0 on the following cycle.
- Hold `refill_pending`=1 and push 4 distinct blocks → `wb_ready`=0 once 4 are held. Drain starts because the buffer is full, and the blocks are written to DRAM in push order.
- Push A=0x20/D1, then A=0x20/D2 while the head is a different block → `count`=1 for 0x20. `rd_addr`=0x20 gives `rd_hit`=1 and `rd_data`=D2, and DRAM later receives D2 only.
- While 0x30/D1 is in WRITE, push 0x30/D2 → a new entry is created and `dram_in` stays D1. A lookup of 0x30 returns D2, and two DRAM writes occur: D1, then D2.
- Full buffer, with pop and `wb_valid` on the same edge → the push is not accepted (`count` 4→3). It is accepted on the next edge with the pointers wrapped.
- Assert `rst`=0 mid-WRITE with 3 entries → on the next edge `count`=0, `dram_we`=0 and `rd_hit`=0 for all prior addresses.
